fb_arbiter: RTL

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arb_pkg.sv | 14 +
 rtl/fb_arb_stats.sv | 32 +++
 rtl/fb_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fb_arb_pkg.sv
// Shared types and default sizing for the frame-buffer arbiter.
package fb_arb_pkg;

  localparam int FB_AW           = 16;
  localparam int FB_DW           = 18;
  localparam int FB_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DISP_BURST = 2'd1,
    BUS_FORCE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fb_arb_stats.sv
// Conflict and forced-grant statistics counters for fb_arbiter (both wrap freely).
module fb_arb_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_conflict,
  input  logic        inc_starve,
  output logic [31:0] stat_conflict,
  output logic [15:0] stat_starve
);

  logic [31:0] conflict_r;
  logic [15:0] starve_r;

  // Event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_r <= 32'd0;
      starve_r   <= 16'd0;
    end else begin
      if (inc_conflict) begin
        conflict_r <= conflict_r + 32'd1;
      end
      if (inc_starve) begin
        starve_r <= starve_r + 16'd1;
      end
    end
  end

  assign stat_conflict = conflict_r;
  assign stat_starve   = starve_r;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer RAM arbiter: display priority with bounded bus starvation.
// Statistics counters are built only when FB_ARB_STATS_EN is defined.
module fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int AW           = FB_AW,
  parameter int DW           = FB_DW,
  parameter int STARVE_LIMIT = FB_STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          disp_req,
  input  logic          disp_last,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          bus_req,
  input  logic          bus_we,
  input  logic [AW-1:0] bus_addr,
  input  logic [DW-1:0] bus_wdata,
  output logic          bus_gnt,
  output logic          bus_rvalid,
  output logic [DW-1:0] bus_rdata,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [31:0]   stat_conflict,
  output logic [15:0]   stat_starve
);

  localparam int            SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] ONE   = SW'(1);

  arb_state_e    state_r;
  arb_state_e    state_nxt_s;
  logic [SW-1:0] starve_cnt_r;
  logic          starved_s;
  logic          disp_gnt_s;
  logic          bus_gnt_s;
  logic          disp_rvalid_r;
  logic          bus_rvalid_r;
  logic [DW-1:0] disp_hold_r;
  logic [DW-1:0] bus_hold_r;

  assign starved_s = (starve_cnt_r == LIMIT);

  // Grant decision and next state; grants are forced low while reset is held
  always_comb begin
    disp_gnt_s  = 1'b0;
    bus_gnt_s   = 1'b0;
    state_nxt_s = state_r;
    if (!rst_n) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (disp_req && !(bus_req && starved_s)) begin
            disp_gnt_s = 1'b1;
            if (disp_last) begin
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = DISP_BURST;
            end
          end else if (bus_req) begin
            bus_gnt_s   = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        DISP_BURST: begin
          // The starved cycle itself is a dead cycle: display is held off before the forced bus slot
          if (starved_s) begin
            state_nxt_s = BUS_FORCE;
          end else if (disp_req) begin
            disp_gnt_s = 1'b1;
            if (disp_last) begin
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = DISP_BURST;
            end
          end else begin
            state_nxt_s = DISP_BURST;
          end
        end
        BUS_FORCE: begin
          // Only reachable from an unfinished burst, so the burst is still open here
          bus_gnt_s   = bus_req;
          state_nxt_s = DISP_BURST;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State, starvation counter and read-return tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      starve_cnt_r  <= '0;
      disp_rvalid_r <= 1'b0;
      bus_rvalid_r  <= 1'b0;
      disp_hold_r   <= '0;
      bus_hold_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (bus_gnt_s) begin
        starve_cnt_r <= '0;
      end else if (bus_req && !starved_s) begin
        starve_cnt_r <= starve_cnt_r + ONE;
      end
      disp_rvalid_r <= disp_gnt_s;
      bus_rvalid_r  <= bus_gnt_s & ~bus_we;
      if (disp_rvalid_r) begin
        disp_hold_r <= ram_dout;
      end
      if (bus_rvalid_r) begin
        bus_hold_r <= ram_dout;
      end
    end
  end

  assign disp_gnt    = disp_gnt_s;
  assign bus_gnt     = bus_gnt_s;
  assign ram_ce      = disp_gnt_s | bus_gnt_s;
  assign ram_we      = bus_gnt_s & bus_we;
  assign ram_addr    = bus_gnt_s ? bus_addr : disp_addr;
  assign ram_din     = bus_gnt_s ? bus_wdata : '0;
  // RAM output is valid exactly in the rvalid cycle; rdata is held otherwise
  assign disp_rvalid = disp_rvalid_r;
  assign bus_rvalid  = bus_rvalid_r;
  assign disp_rdata  = disp_rvalid_r ? ram_dout : disp_hold_r;
  assign bus_rdata   = bus_rvalid_r ? ram_dout : bus_hold_r;

`ifdef FB_ARB_STATS_EN
  logic force_gnt_s;
  assign force_gnt_s = bus_gnt_s & (state_r == BUS_FORCE);

  fb_arb_stats u_stats (
    .clk           (clk),
    .rst_n         (rst_n),
    .inc_conflict  (disp_req & bus_req),
    .inc_starve    (force_gnt_s),
    .stat_conflict (stat_conflict),
    .stat_starve   (stat_starve)
  );
`else
  assign stat_conflict = 32'd0;
  assign stat_starve   = 16'd0;
`endif

endmodule
